// File: rtl/ext_bus_pkg.sv
// Shared encodings for the EXT_BUS host initiator: FSM state codes,
// responder command words and host message codes.
package ext_bus_pkg;

    typedef logic [2:0] ext_state_t;

    localparam ext_state_t ST_IDLE    = 3'd0;
    localparam ext_state_t ST_SETUP   = 3'd1;
    localparam ext_state_t ST_STROBE  = 3'd2;
    localparam ext_state_t ST_WAIT    = 3'd3;
    localparam ext_state_t ST_RELEASE = 3'd4;
    localparam ext_state_t ST_RSP     = 3'd5;

    localparam logic [15:0] EXT_CMD_CD_GET = 16'h0034;
    localparam logic [15:0] EXT_CMD_CD_SET = 16'h0035;

    localparam logic [15:0] MSG_PLAY         = 16'h0035;
    localparam logic [15:0] MSG_PAUSE_SEARCH = 16'h0036;
    localparam logic [15:0] MSG_NEXT_SECTOR  = 16'h0037;
    localparam logic [15:0] MSG_RESET        = 16'h00FF;

endpackage

// File: rtl/ext_bus_host_timer.sv
// Loadable down-counter shared by the SETUP, WAIT and RELEASE phases;
// it parks at zero, so it never wraps.
module ext_bus_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         srst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         done
);

    logic [W-1:0] cnt_r;

    // Count register: reload on request, otherwise step toward zero and hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (srst) begin
            cnt_r <= {W{1'b0}};
        end else if (cnt_r != {W{1'b0}}) begin
            cnt_r <= cnt_r - W'(1);
        end
    end

    assign count = cnt_r;
    assign done  = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/ext_bus_host.sv
// EXT_BUS host initiator: sends one command word plus NWORDS data words
// to the core responder and returns what it drove back on io_dout/dout_en.
module ext_bus_host
    import ext_bus_pkg::*;
#(
    parameter int NWORDS      = 3,
    parameter int SETUP_CYC   = 2,
    parameter int GAP_CYC     = 2,
    parameter int RELEASE_CYC = 4
) (
    input  logic                 sys_clk,
    input  logic                 RESET_N,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [15:0]          req_cmd,
    input  logic [16*NWORDS-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [15:0]          rsp_status,
    output logic [16*NWORDS-1:0] rsp_rdata,
    output logic                 rsp_claimed,
    output logic                 io_enable,
    output logic                 io_strobe,
    output logic [15:0]          io_din,
    input  logic [15:0]          io_dout,
    input  logic                 dout_en
);

    localparam int MAXC = (SETUP_CYC > GAP_CYC)
                        ? ((SETUP_CYC > RELEASE_CYC) ? SETUP_CYC : RELEASE_CYC)
                        : ((GAP_CYC > RELEASE_CYC) ? GAP_CYC : RELEASE_CYC);
    localparam int CW = $clog2(MAXC + 1);
    localparam int WW = $clog2(NWORDS + 1);
    localparam int PW = 16 * NWORDS;

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] REL_LD   = CW'(RELEASE_CYC - 1);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [WW-1:0] LAST_W   = WW'(NWORDS);
    localparam logic [WW-1:0] W_ONE    = WW'(1);

    // Word k on the bus: the command first, then payload only for CD_SET
    function automatic logic [15:0] word_sel(input logic [WW-1:0] idx,
                                             input logic [15:0]   cmd,
                                             input logic [PW-1:0] wdata);
        logic [15:0] sel;
        sel = 16'h0000;
        if (idx == {WW{1'b0}}) begin
            sel = cmd;
        end else if (cmd == EXT_CMD_CD_SET) begin
            for (int k = 0; k < NWORDS; k++) begin
                sel = (idx == WW'(k + 1)) ? wdata[16*k +: 16] : sel;
            end
        end else begin
            sel = 16'h0000;
        end
        return sel;
    endfunction

    ext_state_t      state_r, state_n;
    logic [WW-1:0]   w_r, w_n;
    logic [15:0]     cmd_r;
    logic [PW-1:0]   wdata_r;
    logic [15:0]     rsp_status_r;
    logic [PW-1:0]   rsp_rdata_r;
    logic            rsp_claimed_r, rsp_valid_r, req_ready_r;
    logic            io_enable_r, io_strobe_r;
    logic [15:0]     io_din_r, din_n;
    logic            load_s, accept_s, sample_s, srst_s, done_s;
    logic [CW-1:0]   load_val_s, cnt_s;
    logic            enable_n, strobe_n, ready_n, rsp_valid_n;

    assign srst_s = (state_r == ST_IDLE) && !req_valid;

    ext_bus_timer #(.W(CW)) u_timer (
        .clk      (sys_clk),
        .rst_n    (RESET_N),
        .srst     (srst_s),
        .load     (load_s),
        .load_val (load_val_s),
        .count    (cnt_s),
        .done     (done_s)
    );

    // Next-state, word index, timer reload and bus data selection
    always_comb begin
        state_n    = state_r;
        w_n        = w_r;
        load_s     = 1'b0;
        load_val_s = {CW{1'b0}};
        accept_s   = 1'b0;
        sample_s   = 1'b0;
        din_n      = io_din_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_n    = ST_SETUP;
                    w_n        = {WW{1'b0}};
                    load_s     = 1'b1;
                    load_val_s = SETUP_LD;
                    accept_s   = 1'b1;
                    din_n      = req_cmd;
                end else begin
                    din_n = 16'h0000;
                end
            end
            ST_SETUP: begin
                if (done_s) begin
                    state_n = ST_STROBE;
                end else begin
                    state_n = ST_SETUP;
                end
            end
            ST_STROBE: begin
                state_n    = ST_WAIT;
                load_s     = 1'b1;
                load_val_s = GAP_LD;
            end
            ST_WAIT: begin
                if (done_s) begin
                    sample_s = 1'b1;
                    if (w_r < LAST_W) begin
                        w_n     = w_r + W_ONE;
                        state_n = ST_STROBE;
                    end else begin
                        state_n    = ST_RELEASE;
                        load_s     = 1'b1;
                        load_val_s = REL_LD;
                        din_n      = 16'h0000;
                    end
                end else if ((cnt_s == ONE_C) && (w_r < LAST_W)) begin
                    // Present the next word one cycle ahead of its strobe
                    din_n = word_sel(w_r + W_ONE, cmd_r, wdata_r);
                end else begin
                    din_n = io_din_r;
                end
            end
            ST_RELEASE: begin
                if (done_s) begin
                    state_n = ST_RSP;
                end else begin
                    state_n = ST_RELEASE;
                end
            end
            ST_RSP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
                din_n   = 16'h0000;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop
    always_comb begin
        enable_n    = (state_n == ST_SETUP) || (state_n == ST_STROBE) || (state_n == ST_WAIT);
        strobe_n    = (state_n == ST_STROBE);
        ready_n     = (state_n == ST_IDLE);
        rsp_valid_n = (state_n == ST_RSP);
    end

    // State, bus outputs, request latch and response capture
    always_ff @(posedge sys_clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r       <= ST_IDLE;
            w_r           <= {WW{1'b0}};
            cmd_r         <= 16'h0000;
            wdata_r       <= {PW{1'b0}};
            rsp_status_r  <= 16'h0000;
            rsp_rdata_r   <= {PW{1'b0}};
            rsp_claimed_r <= 1'b0;
            rsp_valid_r   <= 1'b0;
            req_ready_r   <= 1'b1;
            io_enable_r   <= 1'b0;
            io_strobe_r   <= 1'b0;
            io_din_r      <= 16'h0000;
        end else begin
            state_r     <= state_n;
            w_r         <= w_n;
            io_enable_r <= enable_n;
            io_strobe_r <= strobe_n;
            io_din_r    <= din_n;
            req_ready_r <= ready_n;
            rsp_valid_r <= rsp_valid_n;
            if (accept_s) begin
                cmd_r         <= req_cmd;
                wdata_r       <= req_wdata;
                rsp_status_r  <= 16'h0000;
                rsp_rdata_r   <= {PW{1'b0}};
                rsp_claimed_r <= 1'b0;
            end else if (sample_s) begin
                if (w_r == {WW{1'b0}}) begin
                    rsp_status_r  <= io_dout;
                    rsp_claimed_r <= dout_en;
                end else begin
                    for (int k = 0; k < NWORDS; k++) begin
                        if (w_r == WW'(k + 1)) begin
                            rsp_rdata_r[16*k +: 16] <= io_dout;
                        end
                    end
                end
            end
        end
    end

    assign req_ready   = req_ready_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_status  = rsp_status_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_claimed = rsp_claimed_r;
    assign io_enable   = io_enable_r;
    assign io_strobe   = io_strobe_r;
    assign io_din      = io_din_r;

endmodule

// File: tb/tb_ext_bus_host.sv
// Directed bench for ext_bus_host with a behavioural EXT_BUS responder
// and a bus-protocol monitor.
module tb_ext_bus_host;

    logic        sys_clk;
    logic        RESET_N;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_cmd;
    logic [47:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_status;
    logic [47:0] rsp_rdata;
    logic        rsp_claimed;
    logic        io_enable;
    logic        io_strobe;
    logic [15:0] io_din;
    logic [15:0] io_dout;
    logic        dout_en;

    logic [15:0] cd_req;
    logic [47:0] cd_in;
    logic [47:0] cd_out;
    logic [15:0] r_cmd;
    int          r_word;

    int          viol;
    int          low_run;
    int          last_gap;
    logic        prev_strobe;
    logic        prev_enable;
    logic [15:0] prev_din;
    logic [15:0] strobe_q[$];

    int n_cmp;
    int n_mis;

    ext_bus_host dut (
        .sys_clk     (sys_clk),
        .RESET_N     (RESET_N),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cmd     (req_cmd),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_status  (rsp_status),
        .rsp_rdata   (rsp_rdata),
        .rsp_claimed (rsp_claimed),
        .io_enable   (io_enable),
        .io_strobe   (io_strobe),
        .io_din      (io_din),
        .io_dout     (io_dout),
        .dout_en     (dout_en)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Responder: registers its answer one cycle after each strobe
    always @(posedge sys_clk) begin
        if (!RESET_N || !io_enable) begin
            r_word  <= 0;
            io_dout <= 16'h0000;
            dout_en <= 1'b0;
            if (!RESET_N) cd_out <= 48'h0;
        end else if (io_strobe) begin
            r_word <= r_word + 1;
            if (r_word == 0) begin
                r_cmd   <= io_din;
                dout_en <= (io_din == 16'h0034) || (io_din == 16'h0035);
                io_dout <= (io_din == 16'h0034) ? cd_req : 16'h0000;
            end else if (r_cmd == 16'h0034) begin
                io_dout <= cd_in[16*(r_word-1) +: 16];
            end else begin
                io_dout <= 16'h0000;
                if (r_cmd == 16'h0035) cd_out[16*(r_word-1) +: 16] <= io_din;
            end
        end
    end

    // Protocol monitor: strobe qualification, width, data stability, enable gaps
    initial begin
        viol = 0;
        low_run = 0;
        last_gap = 0;
    end
    always @(negedge sys_clk) begin
        if (!RESET_N) begin
            prev_strobe <= 1'b0;
            prev_enable <= 1'b0;
            prev_din    <= 16'h0000;
            low_run     <= 0;
        end else begin
            if (io_strobe && !io_enable)          viol <= viol + 1;
            else if (io_strobe && prev_strobe)    viol <= viol + 1;
            else if (io_strobe && io_din !== prev_din) viol <= viol + 1;
            if (io_strobe) strobe_q.push_back(io_din);
            if (io_enable && !prev_enable) begin
                last_gap <= low_run;
                low_run  <= 0;
            end else if (!io_enable) begin
                low_run <= low_run + 1;
            end
            prev_strobe <= io_strobe;
            prev_enable <= io_enable;
            prev_din    <= io_din;
        end
    end

    task automatic run_txn(input logic [15:0] cmd, input logic [47:0] wd, output int lat);
        @(negedge sys_clk);
        req_cmd   = cmd;
        req_wdata = wd;
        req_valid = 1'b1;
        @(negedge sys_clk);
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(negedge sys_clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        RESET_N   = 1'b1;
        req_valid = 1'b0;
        req_cmd   = 16'h0000;
        req_wdata = 48'h0;
        cd_req    = 16'h0000;
        cd_in     = 48'h0;
        #1 RESET_N = 1'b0;
        repeat (2) @(negedge sys_clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_mis++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_cmp++; if ({io_enable, io_strobe, rsp_valid, rsp_claimed} !== 4'b0000) begin
            n_mis++; $display("FAIL reset_ctrl: got en/stb/vld/clm=%b want 0000", {io_enable, io_strobe, rsp_valid, rsp_claimed});
        end
        n_cmp++; if ({io_din, rsp_status, rsp_rdata} !== 80'h0) begin
            n_mis++; $display("FAIL reset_data: got din=%h status=%h rdata=%h want 0", io_din, rsp_status, rsp_rdata);
        end
        @(negedge sys_clk);
        RESET_N = 1'b1;
    endtask

    task automatic test_cd_set();
        int lat;
        int base;
        logic [15:0] exp_w[4];
        exp_w = '{16'h0035, 16'h0037, 16'h1234, 16'h0000};
        base = strobe_q.size();
        run_txn(16'h0035, 48'h0000_1234_0037, lat);
        n_cmp++; if (lat !== 19) begin n_mis++; $display("FAIL set_latency: got %0d want 19", lat); end
        n_cmp++; if (rsp_claimed !== 1'b1) begin n_mis++; $display("FAIL set_claimed: got %b want 1", rsp_claimed); end
        n_cmp++; if (cd_out !== 48'h0000_1234_0037) begin n_mis++; $display("FAIL set_cd_out: got %h want 000012340037", cd_out); end
        n_cmp++; if (req_ready !== 1'b0) begin n_mis++; $display("FAIL set_ready_in_rsp: got %b want 0", req_ready); end
        n_cmp++; if (strobe_q.size() - base !== 4) begin n_mis++; $display("FAIL set_strobes: got %0d want 4", strobe_q.size() - base); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (strobe_q[base+i] !== exp_w[i]) begin
                n_mis++; $display("FAIL set_word%0d: got %h want %h", i, strobe_q[base+i], exp_w[i]);
            end
        end
        @(negedge sys_clk);
        n_cmp++; if ({req_ready, rsp_valid, rsp_claimed} !== 3'b101) begin
            n_mis++; $display("FAIL set_after_rsp: got rdy/vld/clm=%b want 101", {req_ready, rsp_valid, rsp_claimed});
        end
    endtask

    task automatic test_cd_get();
        int lat;
        int base;
        logic [15:0] exp_w[4];
        exp_w = '{16'h0034, 16'h0000, 16'h0000, 16'h0000};
        cd_in  = 48'h0000_01F4_0036;
        cd_req = 16'h0001;
        base = strobe_q.size();
        run_txn(16'h0034, 48'hFFFF_EEEE_DDDD, lat);
        n_cmp++; if (lat !== 19) begin n_mis++; $display("FAIL get_latency: got %0d want 19", lat); end
        n_cmp++; if (rsp_status !== 16'h0001) begin n_mis++; $display("FAIL get_status: got %h want 0001", rsp_status); end
        n_cmp++; if (rsp_rdata !== 48'h0000_01F4_0036) begin n_mis++; $display("FAIL get_rdata: got %h want 000001f40036", rsp_rdata); end
        n_cmp++; if (rsp_claimed !== 1'b1) begin n_mis++; $display("FAIL get_claimed: got %b want 1", rsp_claimed); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (strobe_q[base+i] !== exp_w[i]) begin
                n_mis++; $display("FAIL get_word%0d: got %h want %h", i, strobe_q[base+i], exp_w[i]);
            end
        end
    endtask

    task automatic test_unclaimed();
        int lat;
        int base;
        base = strobe_q.size();
        run_txn(16'h0010, 48'hAAAA_BBBB_CCCC, lat);
        n_cmp++; if (rsp_claimed !== 1'b0) begin n_mis++; $display("FAIL unclm_claimed: got %b want 0", rsp_claimed); end
        n_cmp++; if ({rsp_status, rsp_rdata} !== 64'h0) begin
            n_mis++; $display("FAIL unclm_rsp: got status=%h rdata=%h want 0", rsp_status, rsp_rdata);
        end
        n_cmp++; if (strobe_q.size() - base !== 4) begin n_mis++; $display("FAIL unclm_strobes: got %0d want 4", strobe_q.size() - base); end
        n_cmp++; if ({strobe_q[base], strobe_q[base+1], strobe_q[base+2], strobe_q[base+3]} !== 64'h0010_0000_0000_0000) begin
            n_mis++; $display("FAIL unclm_words: got %h %h %h %h want 0010 0000 0000 0000",
                              strobe_q[base], strobe_q[base+1], strobe_q[base+2], strobe_q[base+3]);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int exp_cyc;
        int base;
        int vbase;
        base  = strobe_q.size();
        vbase = viol;
        cd_in  = 48'h0000_0000_0001;
        cd_req = 16'h0003;
        @(negedge sys_clk);
        req_cmd   = 16'h0034;
        req_wdata = 48'h0;
        req_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            cyc = 0;
            do begin
                @(negedge sys_clk);
                cyc++;
            end while (rsp_valid !== 1'b1 && cyc < 60);
            exp_cyc = (n == 0) ? 19 : 20;
            n_cmp++; if (cyc !== exp_cyc) begin n_mis++; $display("FAIL b2b_spacing%0d: got %0d want %0d", n, cyc, exp_cyc); end
            if (n > 0) begin
                n_cmp++; if (last_gap < 4) begin n_mis++; $display("FAIL b2b_enable_gap%0d: got %0d want >=4", n, last_gap); end
            end
        end
        req_valid = 1'b0;
        n_cmp++; if (strobe_q.size() - base !== 12) begin n_mis++; $display("FAIL b2b_strobes: got %0d want 12", strobe_q.size() - base); end
        n_cmp++; if (viol !== vbase) begin n_mis++; $display("FAIL b2b_protocol: got %0d violations want 0", viol - vbase); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int k;
        cd_in  = 48'h0000_0BEE_0037;
        cd_req = 16'h0002;
        @(negedge sys_clk);
        req_cmd   = 16'h0034;
        req_wdata = 48'h0;
        req_valid = 1'b1;
        @(negedge sys_clk);
        req_valid = 1'b0;
        k = 1;
        while (k < 10) begin
            @(negedge sys_clk);
            k++;
        end
        n_cmp++; if ({io_enable, io_strobe} !== 2'b10) begin
            n_mis++; $display("FAIL mid_pre_reset: got en/stb=%b want 10", {io_enable, io_strobe});
        end
        RESET_N = 1'b0;
        #1;
        n_cmp++; if ({io_enable, io_strobe, rsp_valid, req_ready} !== 4'b0001) begin
            n_mis++; $display("FAIL mid_async_reset: got en/stb/vld/rdy=%b want 0001", {io_enable, io_strobe, rsp_valid, req_ready});
        end
        @(negedge sys_clk);
        RESET_N = 1'b1;
        run_txn(16'h0034, 48'h0, lat);
        n_cmp++; if (lat !== 19) begin n_mis++; $display("FAIL mid_latency: got %0d want 19", lat); end
        n_cmp++; if ({rsp_claimed, rsp_status, rsp_rdata} !== {1'b1, 16'h0002, 48'h0000_0BEE_0037}) begin
            n_mis++; $display("FAIL mid_get: got clm=%b status=%h rdata=%h want 1 0002 00000bee0037", rsp_claimed, rsp_status, rsp_rdata);
        end
    endtask

    task automatic test_random();
        int lat;
        int pick;
        int base;
        int vbase;
        logic [15:0] cmd;
        logic [47:0] wd;
        logic        bad;
        base  = strobe_q.size();
        vbase = viol;
        for (int n = 0; n < 200; n++) begin
            pick   = int'($urandom_range(0, 2));
            wd     = {16'($urandom), 32'($urandom)};
            cd_in  = {16'($urandom), 32'($urandom)};
            cd_req = 16'($urandom);
            cmd    = (pick == 0) ? 16'h0034 : (pick == 1) ? 16'h0035 : {8'h01, 8'($urandom)};
            repeat ($urandom_range(0, 3)) @(negedge sys_clk);
            run_txn(cmd, wd, lat);
            bad = (lat != 19) || (rsp_claimed !== (pick < 2));
            case (pick)
                0:       bad = bad || (rsp_status !== cd_req) || (rsp_rdata !== cd_in);
                1:       bad = bad || (cd_out !== wd) || (rsp_rdata !== 48'h0);
                default: bad = bad || (rsp_status !== 16'h0) || (rsp_rdata !== 48'h0);
            endcase
            n_cmp++;
            if (bad) begin
                n_mis++;
                $display("FAIL random_txn%0d: cmd=%h lat=%0d clm=%b status=%h rdata=%h want lat=19 cd_in=%h cd_req=%h wd=%h",
                         n, cmd, lat, rsp_claimed, rsp_status, rsp_rdata, cd_in, cd_req, wd);
            end
        end
        n_cmp++; if (strobe_q.size() - base !== 800) begin n_mis++; $display("FAIL random_strobes: got %0d want 800", strobe_q.size() - base); end
        n_cmp++; if (viol !== vbase) begin n_mis++; $display("FAIL random_protocol: got %0d violations want 0", viol - vbase); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_mis = 0;
        test_reset();
        test_cd_set();
        test_cd_get();
        test_unclaimed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
